// File: rtl/issue_operand_stage.sv
// issue_operand_stage
//
// Issue-side operand collection for one decoded instruction per cycle.
// Each source operand is resolved either from its alternate value (imm/PC),
// from x0 (constant zero), or through a priority bypass network:
// byp[0] (youngest) .. byp[NUM_BYP-1], then the writeback port, then the
// combinational register-file read data. A per-register pending-write
// scoreboard decides whether a register operand can be trusted this cycle.
// Accepted instructions are captured in a one-entry output register.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   flush                 kills the output entry and clears the scoreboard
//   in_valid / in_ready   decoded-instruction handshake
//   in_rs1/in_rs2/in_rd   logical register indices
//   in_src*_is_reg        operand comes from a register (else in_src*_alt)
//   in_need_to_wb         instruction will write in_rd
//   in_src*_alt           immediate / PC operand value
//   in_pc, in_inst        passed through to the output entry
//   rf_rs*_addr/_data     combinational register-file read ports
//   byp_valid/rd/data     NUM_BYP flattened bypass sources, index 0 first
//   wb_valid/rd/data      architectural writeback, lowest-priority bypass
//   out_*                 issue handshake and captured instruction fields
//   hazard_stall_cnt      cycles stalled by the scoreboard (not backpressure)

module issue_operand_stage #(
    parameter int XLEN    = 64,
    parameter int NUM_BYP = 3,
    parameter int PC_W    = 48,
    parameter int CNT_W   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic [4:0]              in_rd,
    input  logic                    in_src1_is_reg,
    input  logic                    in_src2_is_reg,
    input  logic                    in_need_to_wb,
    input  logic [XLEN-1:0]         in_src1_alt,
    input  logic [XLEN-1:0]         in_src2_alt,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [31:0]             in_inst,

    output logic [4:0]              rf_rs1_addr,
    output logic [4:0]              rf_rs2_addr,
    input  logic [XLEN-1:0]         rf_rs1_data,
    input  logic [XLEN-1:0]         rf_rs2_data,

    input  logic [NUM_BYP-1:0]      byp_valid,
    input  logic [5*NUM_BYP-1:0]    byp_rd,
    input  logic [XLEN*NUM_BYP-1:0] byp_data,

    input  logic                    wb_valid,
    input  logic [4:0]              wb_rd,
    input  logic [XLEN-1:0]         wb_data,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_src1,
    output logic [XLEN-1:0]         out_src2,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic                    out_need_to_wb,
    output logic [PC_W-1:0]         out_pc,
    output logic [31:0]             out_inst,

    output logic [31:0]             hazard_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Pending-write counters, one per architectural register. Entry 0 is
    // never incremented, so x0 can never look busy.
    logic [CNT_W-1:0] pend [32];

    // Resolved operand values and "some forwarding source hits" flags.
    logic [XLEN-1:0] fwd_val1, fwd_val2;
    logic            fwd_hit1, fwd_hit2;
    logic [XLEN-1:0] src1_val, src2_val;

    logic src1_ready, src2_ready;
    logic rd_saturated;
    logic out_free;
    logic accept;
    logic scoreboard_stall;

    logic [31:0] sb_inc, sb_dec;

    // The register file has no write-through, so the read address is simply
    // the decoded index every cycle.
    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    // ------------------------------------------------------------------
    // Forwarding network. The lowest-priority source is applied first and
    // each higher-priority hit overrides it, so byp[0] wins ties.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_val1 = rf_rs1_data;
        fwd_val2 = rf_rs2_data;
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;

        if (wb_valid && (wb_rd == in_rs1)) begin
            fwd_val1 = wb_data;
            fwd_hit1 = 1'b1;
        end
        if (wb_valid && (wb_rd == in_rs2)) begin
            fwd_val2 = wb_data;
            fwd_hit2 = 1'b1;
        end

        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (byp_valid[i] && (byp_rd[i*5 +: 5] == in_rs1)) begin
                fwd_val1 = byp_data[i*XLEN +: XLEN];
                fwd_hit1 = 1'b1;
            end
            if (byp_valid[i] && (byp_rd[i*5 +: 5] == in_rs2)) begin
                fwd_val2 = byp_data[i*XLEN +: XLEN];
                fwd_hit2 = 1'b1;
            end
        end
    end

    // Final operand mux: alternate value, then hard-wired zero for x0, then
    // whatever the forwarding network produced.
    always_comb begin
        if (!in_src1_is_reg)
            src1_val = in_src1_alt;
        else if (in_rs1 == 5'd0)
            src1_val = '0;
        else
            src1_val = fwd_val1;

        if (!in_src2_is_reg)
            src2_val = in_src2_alt;
        else if (in_rs2 == 5'd0)
            src2_val = '0;
        else
            src2_val = fwd_val2;
    end

    // ------------------------------------------------------------------
    // Readiness. With exactly one write outstanding any forwarding hit must
    // be that write. With two or more, a hit might belong to the older
    // write, so the operand is not trusted until the count drops to one.
    // ------------------------------------------------------------------
    always_comb begin
        src1_ready = !in_src1_is_reg || (in_rs1 == 5'd0) ||
                     (pend[in_rs1] == '0) ||
                     ((pend[in_rs1] == CNT_ONE) && fwd_hit1);
        src2_ready = !in_src2_is_reg || (in_rs2 == 5'd0) ||
                     (pend[in_rs2] == '0) ||
                     ((pend[in_rs2] == CNT_ONE) && fwd_hit2);
    end

    // A writer cannot be accepted while its destination counter is full,
    // otherwise the counter would wrap and lose track of a write.
    assign rd_saturated = in_need_to_wb && (in_rd != 5'd0) &&
                          (pend[in_rd] == CNT_MAX);

    assign out_free = !out_valid || out_ready;

    assign in_ready = !flush && out_free && src1_ready && src2_ready &&
                      !rd_saturated;

    assign accept = in_valid && in_ready;

    // Only stalls that the scoreboard causes are counted; output
    // backpressure and flush cycles are excluded.
    assign scoreboard_stall = in_valid && !flush && out_free && !in_ready;

    // ------------------------------------------------------------------
    // Scoreboard update requests, one bit per register.
    // ------------------------------------------------------------------
    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        for (int r = 1; r < 32; r++) begin
            sb_inc[r] = accept && in_need_to_wb && (in_rd == 5'(r));
            sb_dec[r] = wb_valid && (wb_rd == 5'(r)) && (pend[r] != '0);
        end
    end

    // NOTE: the counter array is reset explicitly; it is only 32 small
    // registers and an unknown count after reset would stall or corrupt
    // the very first dependent instructions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++)
                pend[r] <= '0;
        end else if (flush) begin
            // A writeback landing in the flush cycle is dropped as well.
            for (int r = 0; r < 32; r++)
                pend[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (sb_inc[r] && !sb_dec[r])
                    pend[r] <= pend[r] + CNT_ONE;
                else if (sb_dec[r] && !sb_inc[r])
                    pend[r] <= pend[r] - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // One-entry output register. Operands are captured at accept time, so
    // bypass values are not re-sampled while the entry waits on out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_src1       <= '0;
            out_src2       <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_need_to_wb <= 1'b0;
            out_pc         <= '0;
            out_inst       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_src1       <= src1_val;
            out_src2       <= src2_val;
            out_rs1        <= in_rs1;
            out_rs2        <= in_rs2;
            out_rd         <= in_rd;
            out_need_to_wb <= in_need_to_wb;
            out_pc         <= in_pc;
            out_inst       <= in_inst;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Free-running stall counter; wraps naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            hazard_stall_cnt <= '0;
        else if (scoreboard_stall)
            hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_issue_operand_stage.sv
// Testbench for issue_operand_stage: directed scenarios plus a randomized
// stream, all checked against a behavioural model of the issue rules.

module tb_issue_operand_stage;

    localparam int XLEN  = 64;
    localparam int NB    = 3;
    localparam int PC_W  = 48;
    localparam int CNT_W = 2;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    logic              in_valid, in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
    logic [XLEN-1:0]   in_src1_alt, in_src2_alt;
    logic [PC_W-1:0]   in_pc;
    logic [31:0]       in_inst;
    logic [4:0]        rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
    logic [NB-1:0]     byp_valid;
    logic [5*NB-1:0]   byp_rd;
    logic [XLEN*NB-1:0] byp_data;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   out_src1, out_src2;
    logic [4:0]        out_rs1, out_rs2, out_rd;
    logic              out_need_to_wb;
    logic [PC_W-1:0]   out_pc;
    logic [31:0]       out_inst;
    logic [31:0]       hazard_stall_cnt;

    // Register file contents: register i holds i*0x11.
    logic [XLEN-1:0] rf_mem [32];
    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    issue_operand_stage #(
        .XLEN(XLEN), .NUM_BYP(NB), .PC_W(PC_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
        .in_need_to_wb(in_need_to_wb),
        .in_src1_alt(in_src1_alt), .in_src2_alt(in_src2_alt),
        .in_pc(in_pc), .in_inst(in_inst),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_need_to_wb(out_need_to_wb), .out_pc(out_pc), .out_inst(out_inst),
        .hazard_stall_cnt(hazard_stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model state ----------------
    int              m_pend [32];
    bit              m_valid;
    logic [XLEN-1:0] m_src1, m_src2;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic            m_wb;
    logic [PC_W-1:0] m_pc;
    logic [31:0]     m_inst;
    logic [31:0]     m_stall;

    task automatic m_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_valid = 0; m_src1 = '0; m_src2 = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wb = 1'b0;
        m_pc = '0; m_inst = '0; m_stall = '0;
    endtask

    function automatic bit any_hit(input logic [4:0] r);
        for (int i = 0; i < NB; i++)
            if (byp_valid[i] && byp_rd[i*5 +: 5] == r) return 1'b1;
        return wb_valid && (wb_rd == r);
    endfunction

    function automatic logic [XLEN-1:0] exp_src(input logic is_reg,
                                                 input logic [4:0] r,
                                                 input logic [XLEN-1:0] alt);
        if (!is_reg) return alt;
        if (r == 5'd0) return '0;
        for (int i = 0; i < NB; i++)
            if (byp_valid[i] && byp_rd[i*5 +: 5] == r) return byp_data[i*XLEN +: XLEN];
        if (wb_valid && wb_rd == r) return wb_data;
        return rf_mem[r];
    endfunction

    function automatic bit src_ok(input logic is_reg, input logic [4:0] r);
        return !is_reg || (r == 5'd0) || (m_pend[r] == 0) ||
               ((m_pend[r] == 1) && any_hit(r));
    endfunction

    function automatic bit exp_ready();
        return !flush && (!m_valid || out_ready) &&
               src_ok(in_src1_is_reg, in_rs1) && src_ok(in_src2_is_reg, in_rs2) &&
               !(in_need_to_wb && in_rd != 5'd0 && m_pend[in_rd] == PMAX);
    endfunction

    // Advance one clock: evaluate the model on the current inputs, clock the
    // DUT, and return 1 time unit after the edge.
    task automatic step();
        bit acc;
        acc = in_valid && exp_ready();
        if (in_valid && !flush && (!m_valid || out_ready) && !exp_ready())
            m_stall = m_stall + 32'd1;
        if (flush) begin
            foreach (m_pend[r]) m_pend[r] = 0;
            m_valid = 0;
        end else begin
            if (wb_valid && wb_rd != 5'd0 && m_pend[wb_rd] > 0)
                m_pend[wb_rd] = m_pend[wb_rd] - 1;
            if (acc && in_need_to_wb && in_rd != 5'd0)
                m_pend[in_rd] = m_pend[in_rd] + 1;
            if (acc) begin
                m_valid = 1;
                m_src1  = exp_src(in_src1_is_reg, in_rs1, in_src1_alt);
                m_src2  = exp_src(in_src2_is_reg, in_rs2, in_src2_alt);
                m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
                m_wb = in_need_to_wb; m_pc = in_pc; m_inst = in_inst;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic r1, input logic r2,
                         input logic nwb, input logic [XLEN-1:0] a1,
                         input logic [XLEN-1:0] a2);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_src1_is_reg = r1; in_src2_is_reg = r2; in_need_to_wb = nwb;
        in_src1_alt = a1; in_src2_alt = a2;
        in_pc = PC_W'({$urandom(), $urandom()});
        in_inst = $urandom();
    endtask

    task automatic clear_byp();
        byp_valid = '0; byp_rd = '0;
        for (int i = 0; i < NB; i++) byp_data[i*XLEN +: XLEN] = {$urandom(), $urandom()};
        wb_valid = 1'b0; wb_rd = '0; wb_data = {$urandom(), $urandom()};
    endtask

    task automatic set_byp(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
        byp_valid[i] = 1'b1;
        byp_rd[i*5 +: 5] = rd;
        byp_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        clear_byp();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, '0, '0);
        #12;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++;
        if (out_src1 !== '0 || out_src2 !== '0 || out_pc !== '0 || out_inst !== '0 || out_rd !== '0 || out_need_to_wb !== 1'b0) begin
            bad++; $display("FAIL reset_fields: src1=%h src2=%h pc=%h inst=%h want all 0", out_src1, out_src2, out_pc, out_inst);
        end
        total++;
        if (hazard_stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", hazard_stall_cnt); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        @(posedge clock); #1;
    endtask

    task automatic test_independent();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 5'd2, 5'(10 + k), 1'b1, 1'b1, 1'b0, '0, '0);
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL indep_ready[%0d]: got %b want 1", k, in_ready); end
            total++;
            if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd2) begin
                bad++; $display("FAIL indep_rf_addr[%0d]: got %0d/%0d want 1/2", k, rf_rs1_addr, rf_rs2_addr);
            end
            step();
            total++;
            if (out_valid !== 1'b1 || out_src1 !== 64'h11 || out_src2 !== 64'h22) begin
                bad++; $display("FAIL indep_out[%0d]: valid=%b src1=%h src2=%h want 1/11/22", k, out_valid, out_src1, out_src2);
            end
            total++;
            if (out_pc !== m_pc || out_inst !== m_inst || out_rd !== m_rd) begin
                bad++; $display("FAIL indep_pass[%0d]: pc=%h inst=%h rd=%0d want %h/%h/%0d", k, out_pc, out_inst, out_rd, m_pc, m_inst, m_rd);
            end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        total++;
        if (out_valid !== 1'b0 || hazard_stall_cnt !== 32'd0) begin
            bad++; $display("FAIL indep_drain: valid=%b cnt=%0d want 0/0", out_valid, hazard_stall_cnt);
        end
    endtask

    task automatic test_bypass_priority();
        // Producer of x5, then a consumer seeing byp0, byp2 and wb all for x5.
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 64'h1, 64'h2);
        step();
        drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0, 64'h3);
        set_byp(0, 5'd5, 64'hA); set_byp(2, 5'd5, 64'hC); set_wb(5'd5, 64'hD);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL byp_ready: got %b want 1", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b1 || out_src1 !== 64'hA) begin
            bad++; $display("FAIL byp_prio0: valid=%b src1=%h want 1/a", out_valid, out_src1);
        end
        // wb decremented x5 back to 0: a hit-less reader is ready and reads the rf.
        clear_byp();
        drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL byp_pend_cleared: got %b want 1", in_ready); end
        step();
        total++;
        if (out_src1 !== 64'h55) begin bad++; $display("FAIL byp_rf_read: got %h want 55", out_src1); end
        // Second round: only byp2 and wb hit, so byp2 wins.
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, '0, '0);
        step();
        drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, '0, '0);
        set_byp(2, 5'd5, 64'hC); set_wb(5'd5, 64'hD);
        #1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_src2 !== 64'hC) begin
            bad++; $display("FAIL byp_prio2: valid=%b src2=%h want 1/c", out_valid, out_src2);
        end
        clear_byp();
    endtask

    task automatic test_double_pending();
        logic [31:0] base;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, '0, '0);
            step();
        end
        base = hazard_stall_cnt;
        drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            clear_byp();
            set_byp(0, 5'd7, 64'h70 + 64'(k));
            if (k == 3) set_wb(5'd7, 64'h77);
            #1;
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL dbl_stall[%0d]: got %b want 0", k, in_ready); end
            step();
        end
        clear_byp();
        set_byp(0, 5'd7, 64'h7E);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL dbl_accept: got %b want 1", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b1 || out_src1 !== 64'h7E) begin
            bad++; $display("FAIL dbl_value: valid=%b src1=%h want 1/7e", out_valid, out_src1);
        end
        total++;
        if (hazard_stall_cnt - base !== 32'd4 || hazard_stall_cnt !== m_stall) begin
            bad++; $display("FAIL dbl_cnt: got %0d (delta %0d) want %0d (delta 4)", hazard_stall_cnt, hazard_stall_cnt - base, m_stall);
        end
        // Retire the remaining x7 write.
        clear_byp(); set_wb(5'd7, 64'h0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        clear_byp();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, '0, '0);
            step();
        end
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, '0, '0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) set_wb(5'd9, 64'h9);
            #1;
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL sat_block[%0d]: got %b want 0", k, in_ready); end
            step();
        end
        // Counter now at 2: the writer and a wb on x9 land together.
        set_wb(5'd9, 64'h9);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL sat_accept: got %b want 1", in_ready); end
        step();
        // Still two writes pending: a reader with a hit must stall.
        clear_byp();
        drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        set_byp(1, 5'd9, 64'h99);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL sat_unchanged: got %b want 0", in_ready); end
        set_wb(5'd9, 64'h98);
        step();
        clear_byp(); set_byp(1, 5'd9, 64'h99);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL sat_drain: got %b want 1", in_ready); end
        step();
        total++;
        if (out_src1 !== 64'h99 || hazard_stall_cnt !== m_stall) begin
            bad++; $display("FAIL sat_out: src1=%h cnt=%0d want 99/%0d", out_src1, hazard_stall_cnt, m_stall);
        end
        clear_byp();
    endtask

    task automatic test_x0_nonreg();
        for (int k = 0; k < 5; k++) begin
            clear_byp();
            drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, '0, 64'h1234);
            set_byp(0, 5'd0, 64'hFF);
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready[%0d]: got %b want 1", k, in_ready); end
            step();
            total++;
            if (out_src1 !== 64'h0 || out_src2 !== 64'h1234) begin
                bad++; $display("FAIL x0_value[%0d]: src1=%h src2=%h want 0/1234", k, out_src1, out_src2);
            end
        end
        clear_byp();
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] held;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 64'(k), '0);
            step();
        end
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        held = out_src1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_src1 !== held || out_src1 !== m_src1) begin
            bad++; $display("FAIL flush_hold: valid=%b src1=%h want 1/%h", out_valid, out_src1, m_src1);
        end
        flush = 1'b1;
        drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill: got %b want 0", out_valid); end
        out_ready = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_wb(5'd3, 64'h3);
        step();
        clear_byp();
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, '0, '0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_pend_zero: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_random();
        bit acc;
        clear_byp();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 400; c++) begin
            if (!in_valid)
                drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                      {$urandom(), $urandom()});
            for (int i = 0; i < NB; i++) begin
                byp_valid[i] = 1'($urandom_range(0, 1));
                byp_rd[i*5 +: 5] = 5'($urandom_range(0, 7));
                byp_data[i*XLEN +: XLEN] = {$urandom(), $urandom()};
            end
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = {$urandom(), $urandom()};
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush = 1'($urandom_range(0, 24) == 0);
            #1;
            total++;
            if (in_ready !== exp_ready()) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, exp_ready());
            end
            acc = in_valid && exp_ready();
            step();
            total++;
            if (out_valid !== m_valid || out_src1 !== m_src1 || out_src2 !== m_src2 ||
                out_rs1 !== m_rs1 || out_rs2 !== m_rs2 || out_rd !== m_rd ||
                out_need_to_wb !== m_wb || out_pc !== m_pc || out_inst !== m_inst) begin
                bad++;
                $display("FAIL rnd_out[%0d]: valid=%b src1=%h src2=%h rd=%0d want %b/%h/%h/%0d",
                         c, out_valid, out_src1, out_src2, out_rd, m_valid, m_src1, m_src2, m_rd);
            end
            total++;
            if (hazard_stall_cnt !== m_stall) begin
                bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, hazard_stall_cnt, m_stall);
            end
            if (acc) in_valid = 1'b0;
        end
        flush = 1'b0; out_ready = 1'b1;
        clear_byp();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 64'h44, '0);
        step();
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre: got %b want 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_src1 !== '0 || hazard_stall_cnt !== 32'd0) begin
            bad++; $display("FAIL arst_immediate: valid=%b src1=%h cnt=%0d want 0/0/0", out_valid, out_src1, hazard_stall_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        @(posedge clock); #1;
        out_ready = 1'b1;
        drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_pend: got %b want 1", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b1 || out_src1 !== 64'h44) begin
            bad++; $display("FAIL arst_resume: valid=%b src1=%h want 1/44", out_valid, out_src1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 64'(i) * 64'h11;
        m_reset();
        test_reset();
        test_independent();
        test_bypass_priority();
        test_double_pending();
        test_saturation();
        test_x0_nonreg();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_operand_stage.md
# issue_operand_stage

Parametrised successor to the frontend operand path. It takes one decoded instruction per cycle over a valid/ready handshake and reads both source operands through external combinational register-file ports. Operands are resolved through a priority-ordered bypass network of NUM_BYP sources plus the writeback port, and hazards are tracked in a per-register pending-write scoreboard. The instruction is issued through a one-entry registered output stage toward execute. The block sits between the decoder and the execute stage, and it replaces fixed two-source forwarding.

## Interface
- XLEN, 64, operand/result width
- NUM_BYP, 3, number of bypass sources; index 0 has the highest priority (youngest result)
- PC_W, 48, PC width
- CNT_W, 2, width of each per-register pending-write counter; saturates at 2^CNT_W-1
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  kills the output entry and clears the scoreboard
- in_valid / in_ready  in / out  1  decoded-instruction handshake
- in_rs1, in_rs2, in_rd  in  5 each  logical register indices
- in_src1_is_reg, in_src2_is_reg, in_need_to_wb  in  1 each  decode flags
- in_src1_alt, in_src2_alt  in  XLEN each  operand value used when the corresponding is_reg flag is 0 (imm/PC)
- in_pc  in  PC_W;  in_inst  in  32  passed through to the output
- rf_rs1_addr, rf_rs2_addr  out  5 each  always equal to in_rs1 / in_rs2
- rf_rs1_data, rf_rs2_data  in  XLEN each  combinational regfile read data; no internal write-through
- byp_valid  in  NUM_BYP;  byp_rd  in  5*NUM_BYP;  byp_data  in  XLEN*NUM_BYP  bypass sources
- wb_valid  in  1;  wb_rd  in  5;  wb_data  in  XLEN  architectural writeback; also the lowest-priority bypass source
- out_valid / out_ready  out / in  1  issue handshake
- out_src1, out_src2  out  XLEN;  out_rs1, out_rs2, out_rd  out  5;  out_need_to_wb  out  1;  out_pc  out  PC_W;  out_inst  out  32
- hazard_stall_cnt  out  32  free-running count of scoreboard-stall cycles

## Operation

**Operand select, per source s**
- If is_reg=0, the value is in_s_alt.
- If the register is x0, the value is 0; x0 is never busy and never bypassed.
- Otherwise the first hit wins in this order: byp[0..NUM_BYP-1] (a hit is byp_valid & byp_rd==rs), then wb (wb_valid & wb_rd==rs), then rf data.

**Operand readiness**
- An operand is ready if it is non-reg, or x0, or pend[rs]==0, or (pend[rs]==1 and any bypass/wb hit).
- pend[rs]>=2 always stalls, because the bypass hit may come from the older of the writes.

**Accept condition**
- in_ready = ~flush & (~out_valid | out_ready) & ready1 & ready2 & ~(in_need_to_wb & in_rd!=0 & pend[in_rd]==max).
- The instruction is accepted when in_valid & in_ready.

**Scoreboard update, per register r, per cycle**
- inc = accept & in_need_to_wb & in_rd==r & r!=0.
- dec = wb_valid & wb_rd==r & pend[r]!=0.
- pend[r] += inc - dec.
- A decrement when pend[r]==0 is ignored.
- On flush, all pend[r] become 0, and a writeback in the same cycle is ignored.

**Output register**
- On accept it loads all out_* fields and sets out_valid=1.
- Otherwise, if out_ready, it clears out_valid.
- On flush, out_valid clears and in_ready=0.

**hazard_stall_cnt**
- Increments when in_valid & ~flush & (~out_valid|out_ready) & ~in_ready, i.e. the stall is caused by the scoreboard and not by backpressure.
- Wraps at 2^32.

## Timing
- Reset values: out_valid=0; all out_* data fields 0; all pend counters 0; hazard_stall_cnt 0; in_ready follows its combinational equation with post-reset state (1 when in_valid with no hazards).
- Latency: 1 cycle from accept to out_valid. Bypass data is sampled in the accept cycle and is not re-sampled while the output is held.
- Throughput: 1 instruction per cycle when out_ready=1 and no hazard.
- out_* fields are stable while out_valid & ~out_ready. in_* may change only after acceptance (upstream obeys valid/ready).
- Back-to-back dependent instructions: the consumer stalls until the producer result appears on a bypass port or wb (pend==1 plus a hit), and is accepted in that same cycle.
- Reset asserted mid-operation clears all state asynchronously. Outputs are valid again from the first clock edge after deassertion.

## Test plan
- **Independent stream:** 4 instructions rs1=1, rs2=2 (pend 0), rf data 0x11/0x22, out_ready=1 → out_valid on cycles 1-4, out_src1=0x11, out_src2=0x22, hazard_stall_cnt=0.
- **Bypass priority:** pend[5]=1, rs1=5, byp0 rd=5 data 0xA, byp2 rd=5 data 0xC, wb rd=5 data 0xD → accepted; out_src1=0xA; pend[5] returns to 0 if wb decrements (inc 0, dec 1).
- **Double pending:** issue two writers of x7, then a reader of x7 with byp0 hit → stalls until the first wb_rd=7 brings pend to 1; accepted on the next hit; hazard_stall_cnt equals the stall cycles.
- **Saturation:** with CNT_W=2, three outstanding writers to x9, then a fourth writer to x9 → in_ready=0 until a wb_rd=9 occurs; a simultaneous accept and wb on x9 leaves pend[9] unchanged.
- **x0 / non-reg:** rs1=0 with byp rd=0 data 0xFF gives out_src1=0; a writer with rd=0 never increments pend; is_reg=0 passes in_src_alt=0x1234.
- **Flush and reset:** flush while out_valid & ~out_ready with pend[3]=2 → the next cycle has out_valid=0 and pend all 0; a later wb_rd=3 leaves pend at 0. Async reset mid-stream → out_valid=0 immediately.
